// File: rtl/rpn_pkg.sv
// Shared types and defaults for the RPN operand-stack controller.
// Optional swap support is enabled by defining RPN_SWAP_EN.
package rpn_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [STATE_W-1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        ESCREVE = 2'd2
    } estado_t;

    // Enough to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rpn_pilha.sv
// DEPTH x WIDTH operand stack: push, replace-top-two-with-one, clear and
// (with RPN_SWAP_EN) swap-top-two, plus top/second-top read ports.
module rpn_pilha
    import rpn_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_push,
    input  logic             cmd_replace,
    input  logic             cmd_clear,
`ifdef RPN_SWAP_EN
    input  logic             cmd_swap,
`endif
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] replace_data,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    int               cnt_i;

    // Compare as int so that i+2 never wraps into a small count value.
    always_comb begin
        cnt_i  = int'(count_q);
        top    = '0;
        second = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_i == i + 1) top    = mem_q[i];
            if (cnt_i == i + 2) second = mem_q[i];
        end
    end

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (cmd_clear) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            count_d = '0;
        end else if (cmd_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_i == i) mem_d[i] = push_data;
            end
            count_d = count_q + CNT_W'(1);
        end else if (cmd_replace) begin
            // Result lands in the second-top slot; the vacated top slot is zeroed.
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_i == i + 2) mem_d[i] = replace_data;
                if (cnt_i == i + 1) mem_d[i] = '0;
            end
            count_d = count_q - CNT_W'(1);
        end
`ifdef RPN_SWAP_EN
        else if (cmd_swap) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_i == i + 1) mem_d[i] = second;
                if (cnt_i == i + 2) mem_d[i] = top;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rpn_stack_controller.sv
// RPN stack sequencer feeding the ALU: push / execute / clear with sticky
// overflow/underflow flags. Define RPN_SWAP_EN to add the troca_pulso swap.
module rpn_stack_controller
    import rpn_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enter_pulso,
    input  logic             executar_pulso,
    input  logic             limpar_pulso,
`ifdef RPN_SWAP_EN
    input  logic             troca_pulso,
`endif
    input  logic [WIDTH-1:0] operando_in,
    input  logic [WIDTH-1:0] ula_resultado,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [WIDTH-1:0] topo,
    output logic [CNT_W-1:0] contagem,
    output logic             ocupado,
    output logic             erro_overflow,
    output logic             erro_underflow
);

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             cmd_push, cmd_replace, cmd_clear;
`ifdef RPN_SWAP_EN
    logic             cmd_swap;
`endif
    logic [WIDTH-1:0] top_w, second_w;
    logic [CNT_W-1:0] count_w;
    logic             tem_dois, cheio;

    assign tem_dois = (count_w >= CNT_W'(2));
    assign cheio    = (count_w == CNT_W'(DEPTH));

    rpn_pilha #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_pilha (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_push     (cmd_push),
        .cmd_replace  (cmd_replace),
        .cmd_clear    (cmd_clear),
`ifdef RPN_SWAP_EN
        .cmd_swap     (cmd_swap),
`endif
        .push_data    (operando_in),
        .replace_data (res_q),
        .top          (top_w),
        .second       (second_w),
        .count        (count_w)
    );

    // Pulses are only honoured in OCIOSO; lower-priority ones are dropped.
    always_comb begin
        estado_d    = estado_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        cmd_push    = 1'b0;
        cmd_replace = 1'b0;
        cmd_clear   = 1'b0;
`ifdef RPN_SWAP_EN
        cmd_swap    = 1'b0;
`endif
        unique case (estado_q)
            OCIOSO: begin
                if (limpar_pulso) begin
                    cmd_clear = 1'b1;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                end else if (executar_pulso) begin
                    if (tem_dois) estado_d = EXECUTA;
                    else          unf_d    = 1'b1;
                end
`ifdef RPN_SWAP_EN
                else if (troca_pulso) begin
                    if (tem_dois) cmd_swap = 1'b1;
                    else          unf_d    = 1'b1;
                end
`endif
                else if (enter_pulso) begin
                    if (!cheio) cmd_push = 1'b1;
                    else        ovf_d    = 1'b1;
                end
            end
            EXECUTA: begin
                res_d    = ula_resultado;
                estado_d = ESCREVE;
            end
            ESCREVE: begin
                cmd_replace = 1'b1;
                estado_d    = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign ula_a          = second_w;
    assign ula_b          = top_w;
    assign topo           = top_w;
    assign contagem       = count_w;
    assign ocupado        = (estado_q != OCIOSO);
    assign erro_overflow  = ovf_q;
    assign erro_underflow = unf_q;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// Directed plus randomized bench for rpn_stack_controller against a queue-based stack model.
module tb_rpn_stack_controller;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset_n;
    logic             enter_pulso, executar_pulso, limpar_pulso;
`ifdef RPN_SWAP_EN
    logic             troca_pulso;
`endif
    logic [WIDTH-1:0] operando_in;
    logic [WIDTH-1:0] ula_resultado;
    logic [WIDTH-1:0] ula_a, ula_b, topo;
    logic [CNT_W-1:0] contagem;
    logic             ocupado, erro_overflow, erro_underflow;

    logic             alu_sub;
    int               n_tests, n_fail;

    int               stk[$];
    bit               m_ovf, m_unf;

    rpn_stack_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enter_pulso    (enter_pulso),
        .executar_pulso (executar_pulso),
        .limpar_pulso   (limpar_pulso),
`ifdef RPN_SWAP_EN
        .troca_pulso    (troca_pulso),
`endif
        .operando_in    (operando_in),
        .ula_resultado  (ula_resultado),
        .ula_a          (ula_a),
        .ula_b          (ula_b),
        .topo           (topo),
        .contagem       (contagem),
        .ocupado        (ocupado),
        .erro_overflow  (erro_overflow),
        .erro_underflow (erro_underflow)
    );

    // Stand-in ALU: add or subtract, modulo 2^WIDTH.
    assign ula_resultado = alu_sub ? (ula_a - ula_b) : (ula_a + ula_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = stk.size();
        chk({tag, "/contagem"}, 32'(contagem), n);
        chk({tag, "/topo"}, 32'(topo), (n >= 1) ? stk[n-1] : 0);
        chk({tag, "/ula_b"}, 32'(ula_b), (n >= 1) ? stk[n-1] : 0);
        chk({tag, "/ula_a"}, 32'(ula_a), (n >= 2) ? stk[n-2] : 0);
        chk({tag, "/ovf"}, 32'(erro_overflow), 32'(m_ovf));
        chk({tag, "/unf"}, 32'(erro_underflow), 32'(m_unf));
        chk({tag, "/ocupado"}, 32'(ocupado), 0);
    endtask

    task automatic clear_inputs();
        enter_pulso    = 1'b0;
        executar_pulso = 1'b0;
        limpar_pulso   = 1'b0;
`ifdef RPN_SWAP_EN
        troca_pulso    = 1'b0;
`endif
    endtask

    // One request cycle (plus the busy window for a taken execute), then full check.
    task automatic step(input string tag, input bit l, input bit x, input bit e, input bit t,
                        input logic [WIDTH-1:0] v, input bit poke_busy);
        int n, a, b, r;
        @(negedge clk);
        limpar_pulso   = l;
        executar_pulso = x;
        enter_pulso    = e;
`ifdef RPN_SWAP_EN
        troca_pulso    = t;
`endif
        operando_in    = v;
        @(negedge clk);
        clear_inputs();
        n = stk.size();
        if (l) begin
            stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (x) begin
            if (n >= 2) begin
                a = stk[n-2];
                b = stk[n-1];
                chk({tag, "/busy0"}, 32'(ocupado), 1);
                chk({tag, "/exec_a"}, 32'(ula_a), a);
                chk({tag, "/exec_b"}, 32'(ula_b), b);
                if (poke_busy) begin
                    enter_pulso  = 1'b1;
                    limpar_pulso = 1'b1;
                    operando_in  = 8'hA5;
                end
                @(negedge clk);
                clear_inputs();
                chk({tag, "/busy1"}, 32'(ocupado), 1);
                @(negedge clk);
                r = alu_sub ? ((a - b) & 255) : ((a + b) & 255);
                void'(stk.pop_back());
                void'(stk.pop_back());
                stk.push_back(r);
            end else begin
                chk({tag, "/no_busy"}, 32'(ocupado), 0);
                m_unf = 1;
            end
        end else if (t) begin
            if (n >= 2) begin
                a = stk[n-2];
                stk[n-2] = stk[n-1];
                stk[n-1] = a;
            end else begin
                m_unf = 1;
            end
        end else if (e) begin
            if (n < DEPTH) stk.push_back(int'(v));
            else           m_ovf = 1;
        end
        check_all(tag);
    endtask

    initial begin
        bit l, x, e, t;
        int k;
        n_tests = 0;
        n_fail  = 0;
        m_ovf   = 0;
        m_unf   = 0;
        alu_sub = 1'b0;
        operando_in = '0;
        clear_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_all("reset");

        // Push 5, 3 then add.
        step("push5", 0, 0, 1, 0, 8'd5, 0);
        step("push3", 0, 0, 1, 0, 8'd3, 0);
        step("exec_add", 0, 1, 0, 0, 8'd0, 0);
        chk("exec_add/topo8", 32'(topo), 8);

        // Overflow, then execute still works.
        step("clr1", 1, 0, 0, 0, 8'd0, 0);
        for (int i = 1; i <= 4; i++) step("fill", 0, 0, 1, 0, 8'(i), 0);
        step("push_full", 0, 0, 1, 0, 8'd9, 0);
        chk("push_full/ovf", 32'(erro_overflow), 1);
        step("exec_after_ovf", 0, 1, 0, 0, 8'd0, 0);
        chk("exec_after_ovf/topo7", 32'(topo), 7);

        // Underflow from empty and with one entry.
        step("clr2", 1, 0, 0, 0, 8'd0, 0);
        step("exec_empty", 0, 1, 0, 0, 8'd0, 0);
        chk("exec_empty/unf", 32'(erro_underflow), 1);
        step("push1", 0, 0, 1, 0, 8'd1, 0);
        step("exec_one", 0, 1, 0, 0, 8'd0, 0);
        chk("exec_one/cnt1", 32'(contagem), 1);

        // Simultaneous enter+execute, plus enter/limpar while busy.
        step("clr3", 1, 0, 0, 0, 8'd0, 0);
        step("pushA", 0, 0, 1, 0, 8'd20, 0);
        step("pushB", 0, 0, 1, 0, 8'd30, 0);
        step("enter_exec", 0, 1, 1, 0, 8'd77, 1);
        chk("enter_exec/cnt1", 32'(contagem), 1);
        chk("enter_exec/topo50", 32'(topo), 50);

        // Both flags set, then limpar clears everything.
        step("clr4", 1, 0, 0, 0, 8'd0, 0);
        step("exec_empty2", 0, 1, 0, 0, 8'd0, 0);
        for (int i = 0; i < 5; i++) step("fill2", 0, 0, 1, 0, 8'(8'hF0 + i), 0);
        chk("flags/ovf", 32'(erro_overflow), 1);
        chk("flags/unf", 32'(erro_underflow), 1);
        step("clr5", 1, 0, 0, 0, 8'd0, 0);

        // Reset while in EXECUTA aborts the operation.
        step("pushR1", 0, 0, 1, 0, 8'd11, 0);
        step("pushR2", 0, 0, 1, 0, 8'd22, 0);
        @(negedge clk);
        executar_pulso = 1'b1;
        @(negedge clk);
        clear_inputs();
        chk("rst_mid/busy", 32'(ocupado), 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        stk.delete();
        m_ovf = 0;
        m_unf = 0;
        check_all("rst_mid");
        @(negedge clk);
        check_all("rst_mid_after");

`ifdef RPN_SWAP_EN
        step("pushS6", 0, 0, 1, 0, 8'd6, 0);
        step("pushS2", 0, 0, 1, 0, 8'd2, 0);
        step("swap", 0, 0, 0, 1, 8'd0, 0);
        chk("swap/ula_a", 32'(ula_a), 2);
        chk("swap/ula_b", 32'(ula_b), 6);
        alu_sub = 1'b1;
        step("exec_sub", 0, 1, 0, 0, 8'd0, 0);
        chk("exec_sub/topoFC", 32'(topo), 32'hFC);
        step("clrS", 1, 0, 0, 0, 8'd0, 0);
`endif

        // Randomized mix of requests against the model.
        for (int it = 0; it < 300; it++) begin
            k = int'($urandom_range(0, 99));
            l = (k < 4);
            x = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 1) == 1);
`ifdef RPN_SWAP_EN
            t = ($urandom_range(0, 4) == 0);
`else
            t = 1'b0;
`endif
            alu_sub = $urandom_range(0, 1) == 1;
            step("rand", l, x, e, t, 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rpn_stack_controller.md
Name: rpn_stack_controller

Overview:
Parametrised successor to the fixed A/B/Result sequencer of the 8-bit ALU datapath. It holds a DEPTH-entry operand stack and presents the top two entries to the ALU. On execute it pops both and pushes the ALU result. It sits between the debounced keypad pulses and the ALU, replacing the three enable-driven registers with true RPN stack semantics.

Parameters:
WIDTH, 8, operand/result bit width
DEPTH, 4, stack entries (>=2)
CNT_W, $clog2(DEPTH+1), width of occupancy counter

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
enter_pulso  input  1  one-cycle request: push operando_in
executar_pulso  input  1  one-cycle request: execute ALU op on top two entries
limpar_pulso  input  1  one-cycle request: empty stack, clear error flags
operando_in  input  WIDTH  value to push
ula_resultado  input  WIDTH  combinational ALU result from ula_a/ula_b
ula_a  output  WIDTH  second-from-top entry (0 if count<2)
ula_b  output  WIDTH  top entry (0 if count<1)
topo  output  WIDTH  top entry for display (0 when empty)
contagem  output  CNT_W  current occupancy 0..DEPTH
ocupado  output  1  high while FSM not in OCIOSO
erro_overflow  output  1  sticky: push attempted when full
erro_underflow  output  1  sticky: execute attempted with count<2

Behaviour:
- Reset (reset_n=0 at posedge clk): all entries 0, contagem=0, FSM=OCIOSO, all outputs 0, flags cleared. Reset mid-operation aborts EXECUTA/ESCREVE; no partial write.
- FSM states: OCIOSO, EXECUTA, ESCREVE.
- OCIOSO priority per cycle: limpar_pulso > executar_pulso > enter_pulso; lower-priority simultaneous pulses are dropped silently.
- limpar: contagem<=0, entries<=0, both flags<=0, stay OCIOSO.
- enter, contagem<DEPTH: entry[contagem]<=operando_in, contagem+1; topo updates next cycle (latency 1).
- enter, contagem==DEPTH: no change to stack; erro_overflow<=1.
- executar, contagem>=2: go EXECUTA; ula_a/ula_b already stable from the stack.
- executar, contagem<2: stay OCIOSO, stack unchanged, erro_underflow<=1.
- EXECUTA: one settle cycle for the ALU; sample ula_resultado into internal hold register; go ESCREVE.
- ESCREVE: entry[contagem-2]<=held result, contagem-1, entry[old top]<=0; go OCIOSO. topo shows the result 3 cycles after the executar_pulso edge.
- Pulses arriving while ocupado=1 (EXECUTA/ESCREVE), including limpar, are ignored; the source must wait for ocupado=0.
- Flags are sticky until limpar or reset; they do not block further valid operations.
- Arithmetic is the ALU's concern; the block stores WIDTH bits unchanged, no extension or truncation.

Optional Feature:
Macro RPN_SWAP_EN. When defined: adds input troca_pulso (1 bit), priority below executar and above enter. In OCIOSO with contagem>=2 it swaps the top two entries in one cycle. With contagem<2 it is a no-op that sets erro_underflow. When not defined: the port is absent and no swap logic is generated.

Decomposition:
- Package rpn_pkg: FSM state enum (OCIOSO, EXECUTA, ESCREVE), state width constant, default WIDTH/DEPTH constants.
- One sub-module rpn_pilha: DEPTH x WIDTH register file with synchronous write port, occupancy counter, top/second-top read outputs, and push/replace-top-two/clear commands.
- The FSM and flags live in rpn_stack_controller.

Test Plan:
- Push 5 then 3 (DEPTH=4), executar with ALU=add model -> ula_a=5, ula_b=3 during EXECUTA; topo=8, contagem=1 three cycles after the pulse; ocupado high exactly 2 cycles.
- Push 1,2,3,4, then enter 9 -> contagem stays 4, topo=4, erro_overflow=1; a further executar still succeeds (topo=7 with add).
- From empty, executar -> erro_underflow=1, contagem=0, ocupado never asserts; push 1 then executar -> underflow stays 1, contagem=1.
- Same-cycle enter+executar with contagem=2 -> execute taken, operand not pushed, final contagem=1; enter during EXECUTA -> ignored.
- Set both flags, then limpar -> contagem=0, topo=0, flags 0. Assert reset_n=0 during EXECUTA -> next cycle all outputs 0, FSM OCIOSO.
- With RPN_SWAP_EN: push 6,2, troca -> ula_a=2, ula_b=6; executar with sub model -> topo=0xFC (2-6 mod 256).
